dm_lsu: RTL and testbench
=========================

# dm_lsu

Load/store unit that sits between the CPU datapath and the word-organised data memory and acts as the initiator on that memory's port. It accepts one byte, halfword or word load/store request at a time. It drives the memory's word address, write strobe and write data. Sub-word stores are performed as read-modify-write, and sub-word loads are returned sign- or zero-extended.

## Interface
- No parameters; memory depth fixed at 128 words (word address [8:2]).
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request valid; accepted only when ready=1
- we  in  1  1 = store, 0 = load; sampled with req
- memOp  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
- ld_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- addr  in  32  byte address; bits [31:9] ignored
- wdata  in  32  store data; byte in [7:0], halfword in [15:0]
- ready  out  1  unit idle, can accept req
- done  out  1  one-cycle pulse, request complete
- err  out  1  valid with done; misaligned or reserved memOp
- rdata  out  32  load result, valid with done
- dm_addr  out  7  word address to memory (addr[8:2] of latched request)
- dm_wr  out  1  memory write strobe; the memory writes on the rising edge while it is high
- dm_din  out  32  memory write data
- dm_dout  in  32  memory read data, combinational from dm_addr

## Operation
- States: IDLE, RD, WR, RESP.
- Request handling:
  - IDLE: ready=1. When req=1, latch addr, we, memOp, ld_unsigned and wdata.
  - Next state from IDLE on accept: error case → RESP; load → RD; word store → WR; byte/halfword store → RD.
- Error cases: memOp=11; halfword with addr[0]=1; word with addr[1:0]≠00.
- RD: capture dm_dout into rbuf. Load → RESP. Sub-word store → WR.
- WR: dm_wr=1 for exactly one cycle. dm_din is either wdata (word store) or rbuf with the target lane replaced. → RESP.
- RESP: done=1 for one cycle; err and rdata valid. → IDLE.
- Byte lanes are little-endian: byte k (addr[1:0]=k) occupies [8k+7:8k]. Halfword at addr[1]=h occupies [16h+15:16h].
- Load extraction: select the lane from rbuf, then extend to 32 bits. Sign-extend uses the lane MSB; ld_unsigned=1 zero-fills.
- Word load returns rbuf unchanged.
- On an error completion: rdata=0, err=1, no memory write is ever issued.
- req while ready=0 is ignored; it is neither queued nor latched.
- dm_addr holds the latched word address from the accept cycle until the next accept.

## Timing
- Accept edge T (the cycle with req=1 and ready=1). Completions:
  - Load: RD in T+1, done in T+2.
  - Word store: dm_wr in T+1, done in T+2.
  - Sub-word store: RD in T+1, WR in T+2, done in T+3.
  - Error: done/err in T+1.
- ready=0 from T+1 until the RESP cycle ends. ready=1 again in the cycle after RESP, so back-to-back requests are allowed every 3–4 cycles.
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, dm_addr=0, dm_wr=0, dm_din=0; rbuf and latched request cleared.
- rst asserted mid-operation (any state): immediately to IDLE with dm_wr=0, so no write occurs on the following edge. The in-flight request is dropped without a done pulse.
- done, err and rdata are registered. They are low/zero outside RESP.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x40 → one dm_wr pulse at word 0x10 with dm_din=0xDEADBEEF, done at T+2. Load word 0x40 → rdata=0xDEADBEEF, err=0.
- Byte RMW: memory word 0x10 = 0x11223344; store byte 0xAA at 0x42 → RD, then WR with dm_din=0x11AA3344, done at T+3.
- Sign/zero extension: word = 0x80F07F01. Load byte at addr[1:0]=2 signed → 0xFFFFFFF0; unsigned → 0x000000F0. Load halfword at 0x42 signed → 0xFFFF80F0.
- Errors: halfword at 0x41, word at 0x42, and memOp=11 → done with err=1 at T+1, rdata=0, dm_wr never asserted.
- Reset mid-store: assert rst during WR of a sub-word store → dm_wr falls immediately, memory word unchanged, no done, ready=1 after release.
- Busy ignore: pulse req with a different address while in RD → ignored; original request completes with correct data, and the second request is only accepted when ready=1.

Source files
------------

// File: rtl/dm_lsu.sv
// Load/store unit driving a 128-word data memory: byte/halfword/word access,
// sub-word stores done as read-modify-write, sub-word loads sign/zero extended.
`timescale 1ns/1ps
module dm_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  memOp,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [6:0]  dm_addr,
  output logic        dm_wr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] OP_B = 2'd0;
  localparam logic [1:0] OP_H = 2'd1;
  localparam logic [1:0] OP_W = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic        we_reg, uns_reg;
  logic [1:0]  op_reg, ofs_reg;
  logic [31:0] wdata_reg, rbuf_reg;
  logic [6:0]  dm_addr_reg;
  logic        done_reg, err_reg;
  logic [31:0] rdata_reg;

  logic        accept, req_bad;
  logic [3:0]  lane_en;
  logic [31:0] lane_data, merged, load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:9];

  assign accept = req && (state_reg == IDLE);

  always_comb begin
    req_bad = (memOp == 2'b11) ||
              ((memOp == OP_H) && addr[0]) ||
              ((memOp == OP_W) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_bad)
            state_next = RESP;
          else if (!we || (memOp != OP_W))
            state_next = RD;
          else
            state_next = WR;
        end
      end
      RD:      state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Store lanes: data replicated across the word, enables pick the target lane(s).
  // A word store enables all four lanes, so rbuf never reaches dm_din for it.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = wdata_reg;
    case (op_reg)
      OP_B: begin
        lane_en   = 4'b0001 << ofs_reg;
        lane_data = {4{wdata_reg[7:0]}};
      end
      OP_H: begin
        lane_en   = ofs_reg[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_reg[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8] : rbuf_reg[8*gi +: 8];
    end
  endgenerate

  // Load extraction reads dm_dout directly so the result registers on the RD edge.
  always_comb begin
    byte_lane = dm_dout[{ofs_reg, 3'b000} +: 8];
    half_lane = dm_dout[{ofs_reg[1], 4'b0000} +: 16];
    case (op_reg)
      OP_B:    load_val = {{24{~uns_reg & byte_lane[7]}}, byte_lane};
      OP_H:    load_val = {{16{~uns_reg & half_lane[15]}}, half_lane};
      default: load_val = dm_dout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      uns_reg     <= 1'b0;
      op_reg      <= 2'b00;
      ofs_reg     <= 2'b00;
      wdata_reg   <= 32'h0;
      rbuf_reg    <= 32'h0;
      dm_addr_reg <= 7'h0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg      <= we;
            op_reg      <= memOp;
            uns_reg     <= ld_unsigned;
            ofs_reg     <= addr[1:0];
            wdata_reg   <= wdata;
            dm_addr_reg <= addr[8:2];
            if (req_bad) begin
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              rdata_reg <= 32'h0;
            end
          end
        end
        RD: begin
          rbuf_reg <= dm_dout;
          if (!we_reg) begin
            done_reg  <= 1'b1;
            rdata_reg <= load_val;
          end
        end
        WR: done_reg <= 1'b1;
        default: begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= 32'h0;
        end
      endcase
    end
  end

  // Write strobe decodes straight from state so reset kills it between edges.
  assign dm_wr   = (state_reg == WR);
  assign dm_din  = (state_reg == WR) ? merged : 32'h0;
  assign dm_addr = dm_addr_reg;
  assign ready   = (state_reg == IDLE);
  assign done    = done_reg;
  assign err     = err_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: memory model on the dm_* port, reference memory
// and load/store models produce expected responses and write transactions.
`timescale 1ns/1ps
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst, req, we, ld_unsigned;
  logic [1:0]  memOp;
  logic [31:0] addr, wdata;
  logic        ready, done, err, dm_wr;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [6:0]  dm_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } rsp_t;
  typedef struct { logic [6:0] a; logic [31:0] d; int at; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];
  logic        pre_we   = 1'b0;
  logic [6:0]  pre_addr = 7'h0;
  logic [31:0] pre_data = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_lsu dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .memOp(memOp),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_wr) mem[dm_addr] <= dm_din;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] op, input logic u,
                                           input logic [1:0] ofs, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ofs +: 8];
    h = w[16*ofs[1] +: 16];
    case (op)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_model(input logic [1:0] op, input logic [1:0] ofs,
                                           input logic [31:0] old, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (op)
      2'd0:    r[8*ofs +: 8] = d[7:0];
      2'd1:    r[16*ofs[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (dm_wr) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(dm_addr), 32'(w.a));
        check("wr_data", dm_din, w.d);
        check("wr_cycle", cyc, w.at);
      end
    end
    if (done) begin
      check("done_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rdata", rdata, r.rdata);
        check("err", 32'(err), 32'(r.err));
        check("latency", cyc - r.acc, r.lat);
      end
    end else if (err || rdata != 32'h0) begin
      check("idle_err", 32'(err), 32'd0);
      check("idle_rdata", rdata, 32'h0);
    end
  end

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [1:0] op, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    logic       bad_req;
    logic [6:0] wi;
    rsp_t       r;
    wr_t        x;
    @(negedge clk);
    for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
    check("ready_wait", 32'(ready), 32'd1);
    bad_req = (op == 2'd3) || (op == 2'd1 && a[0]) || (op == 2'd2 && a[1:0] != 2'b00);
    req = 1'b1; we = w; memOp = op; ld_unsigned = u; addr = a; wdata = d;
    wi = a[8:2];
    r.acc = cyc; r.err = bad_req; r.rdata = 32'h0; r.lat = 1;
    if (!bad_req && !w) begin
      r.lat = 2;
      r.rdata = ld_model(op, u, a[1:0], ref_mem[wi]);
    end else if (!bad_req) begin
      r.lat = (op == 2'd2) ? 2 : 3;
      ref_mem[wi] = st_model(op, a[1:0], ref_mem[wi], d);
      x.a = wi; x.d = ref_mem[wi]; x.at = cyc + r.lat - 1;
      wr_q.push_back(x);
    end
    rsp_q.push_back(r);
    $display("txn we=%0d op=%0d uns=%0d addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d lat=%0d",
             w, op, u, a, d, r.rdata, bad_req, r.lat);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("ready_low", 32'(ready), 32'd0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (!seen) begin
      rsp_q.delete();
      wr_q.delete();
    end else begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("ready_after", 32'(ready), 32'd1);
      check("sb_empty", 32'(rsp_q.size()), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] ra;
    rst = 1'b1; req = 1'b0; we = 1'b0; memOp = 2'd0; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    check("rst_dm_din", dm_din, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // word store then load
    preload(7'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF); wait_done();
    check("mem_word_store", mem[16], 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0); wait_done();

    // byte read-modify-write
    preload(7'h10, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h42, 32'h000000AA); wait_done();
    check("mem_byte_rmw", mem[16], 32'h11AA3344);

    // sign / zero extension
    preload(7'h10, 32'h80F07F01);
    issue(1'b0, 2'd0, 1'b0, 32'h42, 32'h0); wait_done();
    issue(1'b0, 2'd0, 1'b1, 32'h42, 32'h0); wait_done();
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0); wait_done();
    issue(1'b0, 2'd1, 1'b1, 32'h42, 32'h0); wait_done();
    issue(1'b0, 2'd1, 1'b0, 32'h40, 32'h0); wait_done();
    issue(1'b0, 2'd0, 1'b0, 32'h43, 32'h0); wait_done();
    issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0); wait_done();

    // halfword and byte stores on another word
    preload(7'h11, 32'h12345678);
    issue(1'b1, 2'd1, 1'b0, 32'h46, 32'hCAFEBEEF); wait_done();
    check("mem_half_store", mem[17], 32'hBEEF5678);
    issue(1'b1, 2'd0, 1'b0, 32'h45, 32'h12345699); wait_done();
    check("mem_byte_store", mem[17], 32'hBEEF9978);

    // error cases, none may write
    issue(1'b0, 2'd1, 1'b0, 32'h41, 32'h0); wait_done();
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0); wait_done();
    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0); wait_done();
    issue(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000FFFF); wait_done();
    issue(1'b1, 2'd2, 1'b0, 32'h43, 32'h55555555); wait_done();
    issue(1'b1, 2'd3, 1'b0, 32'h40, 32'h66666666); wait_done();
    check("mem_after_errors", mem[16], 32'h80F07F01);

    // random mix over a small window, upper address bits randomised
    for (int i = 0; i < 8; i++) preload(7'(32 + i), $urandom);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      ra[8:0] = 9'h080 + 9'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ra, $urandom);
      wait_done();
    end

    // request while busy is ignored
    preload(7'h7C, 32'h0BADF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    req = 1'b1; we = 1'b1; memOp = 2'd2; addr = 32'h1F0; wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check("busy_no_done", 32'(done), 32'd0);
    end
    check("busy_mem", mem[7'h7C], 32'h0BADF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h1F0, 32'h0); wait_done();

    // reset during the write cycle of a byte store
    preload(7'h30, 32'hCAFEF00D);
    issue(1'b1, 2'd0, 1'b0, 32'hC1, 32'h00000055);
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = dm_wr;
    end
    check("wr_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wr_drop", 32'(dm_wr), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    rsp_q.delete();
    wr_q.delete();
    ref_mem[7'h30] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_kept", mem[7'h30], 32'hCAFEF00D);
    check("rst_release_ready", 32'(ready), 32'd1);
    check("rst_no_done", 32'(done), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'hC0, 32'h0); wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
